key_conditioner: RTL

Input-side front end for the DE10-Lite push-buttons: synchronizes the raw active-low `KEY` pins to `CLOCK_50`, debounces each key independently and emits clean single-cycle press, release and long-press events plus a debounced level. It sits between the board top level and consumer logic such as the stopwatch controller, which then never touches raw button pins.

---
 rtl/key_cond_pkg.sv | 23 ++
 rtl/key_channel.sv | 134 +++++++++++++
 rtl/key_conditioner.sv | 42 ++++
 3 files changed

// File: rtl/key_cond_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Latency: n/a (declarations only).
// Backpressure: n/a (no flow control on key events).
package key_cond_pkg;

  // Per-key debounce/hold FSM states.
  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEB_PRESS   = 2'd1,
    HELD        = 2'd2,
    DEB_RELEASE = 2'd3
  } kc_state_t;

  // 20 ms debounce and 1 s long-press at a 50 MHz clock.
  localparam int KC_DEB_CYC_DEF  = 1_000_000;
  localparam int KC_LONG_CYC_DEF = 50_000_000;

  // Width of a counter that must reach n-1. Never narrower than one bit.
  function automatic int kc_cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold counter.
// Latency: press/release pulse one cycle after edge E+2+DEB_CYC (E = first edge sampling the new level).
// Backpressure: none; events are single-cycle pulses that consumers must sample.
//
// Ports:
//   i_clk, i_reset    clock, synchronous active-high reset
//   i_key_n           raw active-low button, asynchronous to i_clk
//   o_level           debounced state, 1 = pressed
//   o_press/o_release one-cycle pulses on accepted press/release
//   o_long            one-cycle pulse when the hold reaches LONG_CYC cycles
module key_channel
  import key_cond_pkg::*;
#(
  parameter int DEB_CYC  = KC_DEB_CYC_DEF,
  parameter int LONG_CYC = KC_LONG_CYC_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key_n,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long
);

  localparam int DW = kc_cnt_w(DEB_CYC);
  localparam int HW = kc_cnt_w(LONG_CYC);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYC - 1);

  logic          r_sync1, r_sync2;
  kc_state_t     r_state;
  logic [DW-1:0] r_dcnt;
  logic [HW-1:0] r_hcnt;
  logic          r_level, r_press, r_release, r_long;

  kc_state_t     w_state_nxt;
  logic [DW-1:0] w_dcnt_nxt;
  logic [HW-1:0] w_hcnt_nxt;
  logic          w_level_nxt, w_press_nxt, w_release_nxt, w_long_nxt;
  logic          w_hold_run;

  // The hold counter runs through release debounce too, so a long press can
  // still complete while a release is being qualified. It saturates.
  assign w_hold_run = ((r_state == HELD) || (r_state == DEB_RELEASE)) &&
                      (r_hcnt != HOLD_LAST);

  always_comb begin
    w_state_nxt   = r_state;
    w_dcnt_nxt    = r_dcnt;
    w_hcnt_nxt    = r_hcnt;
    w_level_nxt   = r_level;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    w_long_nxt    = 1'b0;

    if (w_hold_run) begin
      w_hcnt_nxt = r_hcnt + 1'b1;
      // Fires only on the step into the saturation value: once per press.
      w_long_nxt = (r_hcnt == HOLD_LAST - 1'b1);
    end

    case (r_state)
      IDLE: begin
        if (!r_sync2) begin
          w_state_nxt = DEB_PRESS;
          w_dcnt_nxt  = '0;
        end
      end
      DEB_PRESS: begin
        if (r_sync2) begin
          w_state_nxt = IDLE;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt = HELD;
          w_press_nxt = 1'b1;
          w_level_nxt = 1'b1;
          w_hcnt_nxt  = '0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      HELD: begin
        if (r_sync2) begin
          w_state_nxt = DEB_RELEASE;
          w_dcnt_nxt  = '0;
        end
      end
      DEB_RELEASE: begin
        if (!r_sync2) begin
          w_state_nxt = HELD;
        end else if (r_dcnt == DEB_LAST) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
          w_level_nxt   = 1'b0;
        end else begin
          w_dcnt_nxt = r_dcnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      // Synchronizer reloads "released" so a key held through reset is
      // re-debounced from scratch, including the synchronizer delay.
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_state   <= IDLE;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
    end else begin
      r_sync1   <= i_key_n;
      r_sync2   <= r_sync1;
      r_state   <= w_state_nxt;
      r_dcnt    <= w_dcnt_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_level   <= w_level_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
      r_long    <= w_long_nxt;
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;

endmodule

// File: rtl/key_conditioner.sv
// Push-button front end: N_KEYS independent synchronize/debounce channels.
// Latency: press/release pulse one cycle after edge E+2+DEB_CYC; long pulse after edge P+LONG_CYC-1.
// Backpressure: none; all outputs are registered single-cycle events or levels.
//
// Ports:
//   CLOCK_50     system clock
//   reset        synchronous active-high reset
//   KEY          raw active-low buttons (asynchronous)
//   key_level    debounced pressed state per key
//   key_press    press pulses; key_release release pulses; key_long long-press pulses
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS   = 2,
  parameter int DEB_CYC  = KC_DEB_CYC_DEF,
  parameter int LONG_CYC = KC_LONG_CYC_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEB_CYC (DEB_CYC),
      .LONG_CYC(LONG_CYC)
    ) u_ch (
      .i_clk    (CLOCK_50),
      .i_reset  (reset),
      .i_key_n  (KEY[g]),
      .o_level  (key_level[g]),
      .o_press  (key_press[g]),
      .o_release(key_release[g]),
      .o_long   (key_long[g])
    );
  end

endmodule
